// File: rtl/frac_div_pkg.sv
// Shared types and helpers for the fractional clock-divider scheduler.
// The config struct carries base divisor D and the num/den frame fraction.
package frac_div_pkg;

   localparam int unsigned DivW  = 8;
   localparam int unsigned FracW = 8;

   typedef enum logic {StIdle, StRun} state_e;

   typedef struct packed {
      logic [DivW-1:0]  div;
      logic [FracW-1:0] num;
      logic [FracW-1:0] den;
   } cfg_t;

   function automatic logic cfg_legal(cfg_t c);
      return (c.div >= DivW'(2)) && (c.den != '0) && (c.num <= c.den);
   endfunction

endpackage

// File: rtl/frac_div_period_gen.sv
// Plays out one output period of len_i cycles per start pulse: clk_out high for
// the first floor(len/2) cycles, tick on cycle 0, last_cycle on cycle len-1.
module frac_div_period_gen #(
   parameter int unsigned LW = 9
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic          start_i,
   input  logic [LW-1:0] len_i,
   output logic          clk_out_o,
   output logic          tick_o,
   output logic          last_cycle_o
);

   logic          busy_q;
   logic [LW-1:0] cnt_q, cnt_d, len_q;
   logic          clk_q, tick_q;

   assign cnt_d        = cnt_q + LW'(1);
   assign last_cycle_o = busy_q & (cnt_q == len_q - LW'(1));
   assign clk_out_o    = clk_q;
   assign tick_o       = tick_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         busy_q <= 1'b0;
         cnt_q  <= '0;
         len_q  <= '0;
         clk_q  <= 1'b0;
         tick_q <= 1'b0;
      end else if (start_i) begin
         busy_q <= 1'b1;
         cnt_q  <= '0;
         len_q  <= len_i;
         clk_q  <= (len_i >> 1) != '0;
         tick_q <= 1'b1;
      end else if (busy_q && !last_cycle_o) begin
         cnt_q  <= cnt_d;
         clk_q  <= cnt_d < (len_q >> 1);
         tick_q <= 1'b0;
      end else begin
         // No follow-on period: park with the output low.
         busy_q <= 1'b0;
         clk_q  <= 1'b0;
         tick_q <= 1'b0;
      end
   end

endmodule

// File: rtl/frac_div_sched.sv
// Fractional clock-divider scheduler: den periods per frame, num of them D+1 long,
// spread by an accumulator. New configs wait in a pending slot for a frame boundary.
module frac_div_sched
   import frac_div_pkg::*;
#(
   parameter int unsigned DW = DivW,
   parameter int unsigned FW = FracW
) (
   input  logic          clk_in,
   input  logic          rst,
   input  logic          en,
   input  logic          cfg_valid,
   output logic          cfg_ready,
   input  logic [DW-1:0] cfg_div,
   input  logic [FW-1:0] cfg_num,
   input  logic [FW-1:0] cfg_den,
   output logic          clk_out,
   output logic          tick,
   output logic          frame_start,
   output logic          cfg_err
);

   state_e        state_q;
   cfg_t          act_q, pend_q, cfg_in, sel_cfg;
   logic          act_vld_q, pend_vld_q;
   logic [FW-1:0] acc_q, acc_d, pidx_q;
   logic [FW:0]   sum;
   logic [DW:0]   len;
   logic          accept, last_cycle, frame_end, start, new_frame, long_per;
   logic          frame_start_q, cfg_err_q;

   assign cfg_in      = '{div: cfg_div, num: cfg_num, den: cfg_den};
   assign cfg_ready   = ~pend_vld_q;
   assign accept      = cfg_valid & ~pend_vld_q;
   assign frame_end   = last_cycle & (pidx_q == act_q.den - FW'(1));
   assign frame_start = frame_start_q;
   assign cfg_err     = cfg_err_q;

   always_comb begin
      start     = 1'b0;
      new_frame = 1'b0;
      case (state_q)
         StIdle: begin
            start     = en & (pend_vld_q | act_vld_q);
            new_frame = 1'b1;
         end
         StRun: begin
            // Leave only at a frame boundary when en has dropped.
            start     = last_cycle & (~frame_end | en);
            new_frame = frame_end;
         end
         default: ;
      endcase
      sel_cfg  = (new_frame && pend_vld_q) ? pend_q : act_q;
      sum      = (new_frame ? '0 : {1'b0, acc_q}) + {1'b0, sel_cfg.num};
      long_per = sum >= {1'b0, sel_cfg.den};
      acc_d    = long_per ? FW'(sum - {1'b0, sel_cfg.den}) : sum[FW-1:0];
      len      = {1'b0, sel_cfg.div} + {{DW{1'b0}}, long_per};
   end

   always_ff @(posedge clk_in or negedge rst) begin
      if (!rst) begin
         state_q       <= StIdle;
         act_q         <= '0;
         pend_q        <= '0;
         act_vld_q     <= 1'b0;
         pend_vld_q    <= 1'b0;
         acc_q         <= '0;
         pidx_q        <= '0;
         frame_start_q <= 1'b0;
         cfg_err_q     <= 1'b0;
      end else begin
         cfg_err_q     <= accept & ~cfg_legal(cfg_in);
         frame_start_q <= start & new_frame;
         if (start) begin
            acc_q  <= acc_d;
            pidx_q <= new_frame ? '0 : pidx_q + FW'(1);
            if (new_frame && pend_vld_q) begin
               act_q      <= pend_q;
               act_vld_q  <= 1'b1;
               pend_vld_q <= 1'b0;
            end
         end
         // accept implies the slot is empty, so this never races the consume above.
         if (accept && cfg_legal(cfg_in)) begin
            pend_q     <= cfg_in;
            pend_vld_q <= 1'b1;
         end
         case (state_q)
            StIdle:  if (start) state_q <= StRun;
            StRun:   if (frame_end && !en) state_q <= StIdle;
            default: state_q <= StIdle;
         endcase
      end
   end

   frac_div_period_gen #(
      .LW (DW + 1)
   ) u_period_gen (
      .clk_i        (clk_in),
      .rst_ni       (rst),
      .start_i      (start),
      .len_i        (len),
      .clk_out_o    (clk_out),
      .tick_o       (tick),
      .last_cycle_o (last_cycle)
   );

endmodule

// File: tb/tb_frac_div_sched.sv
// Bench for frac_div_sched: directed scenarios plus random traffic, checked every
// cycle against a model that precomputes each frame's waveform from num/den/D.
module tb_frac_div_sched;

   logic       clk_in = 1'b0;
   logic       rst, en, cfg_valid;
   logic [7:0] cfg_div, cfg_num, cfg_den;
   logic       cfg_ready, clk_out, tick, frame_start, cfg_err;

   int checks = 0;
   int errors = 0;

   // Model state: frame queue entries are {clk_out, tick, frame_start} per cycle.
   bit         m_run, m_err, act_v, pnd_v;
   int         act_d, act_n, act_m, pnd_d, pnd_n, pnd_m;
   logic [2:0] fq[$];

   frac_div_sched dut (
      .clk_in      (clk_in),
      .rst         (rst),
      .en          (en),
      .cfg_valid   (cfg_valid),
      .cfg_ready   (cfg_ready),
      .cfg_div     (cfg_div),
      .cfg_num     (cfg_num),
      .cfg_den     (cfg_den),
      .clk_out     (clk_out),
      .tick        (tick),
      .frame_start (frame_start),
      .cfg_err     (cfg_err)
   );

   always #5 clk_in = ~clk_in;

   task automatic chk(string tag, logic got, logic exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s at %0t: observed %b expected %b", tag, $time, got, exp);
      end
   endtask

   task automatic model_reset();
      m_run = 0; m_err = 0; act_v = 0; pnd_v = 0;
      fq.delete();
   endtask

   task automatic build_frame(int d, int n, int m);
      int acc, len;
      logic b2, b1, b0;
      fq.delete();
      acc = 0;
      for (int p = 0; p < m; p++) begin
         acc = acc + n;
         len = d;
         if (acc >= m) begin
            len = d + 1;
            acc = acc - m;
         end
         for (int k = 0; k < len; k++) begin
            b2 = (k < len / 2);
            b1 = (k == 0);
            b0 = (k == 0) && (p == 0);
            fq.push_back({b2, b1, b0});
         end
      end
   endtask

   task automatic load_frame();
      if (pnd_v) begin
         act_d = pnd_d; act_n = pnd_n; act_m = pnd_m;
         act_v = 1; pnd_v = 0;
      end
      build_frame(act_d, act_n, act_m);
   endtask

   // Advance the model across one clock edge using the inputs currently driven.
   task automatic model_step();
      bit acc_ok, legal;
      legal  = (cfg_div >= 8'd2) && (cfg_den != 8'd0) && (cfg_num <= cfg_den);
      acc_ok = cfg_valid && !pnd_v;
      m_err  = acc_ok && !legal;
      if (m_run) begin
         void'(fq.pop_front());
         if (fq.size() == 0) begin
            if (en) load_frame();
            else m_run = 0;
         end
      end else if (en && (pnd_v || act_v)) begin
         load_frame();
         m_run = 1;
      end
      if (acc_ok && legal) begin
         pnd_d = int'(cfg_div); pnd_n = int'(cfg_num); pnd_m = int'(cfg_den);
         pnd_v = 1;
      end
   endtask

   task automatic check_all();
      logic [2:0] e;
      e = m_run ? fq[0] : 3'b000;
      chk("clk_out", clk_out, e[2]);
      chk("tick", tick, e[1]);
      chk("frame_start", frame_start, e[0]);
      chk("cfg_ready", cfg_ready, !pnd_v);
      chk("cfg_err", cfg_err, m_err);
   endtask

   task automatic cycle();
      model_step();
      @(posedge clk_in);
      #1;
      check_all();
   endtask

   task automatic run(int n);
      for (int i = 0; i < n; i++) cycle();
   endtask

   // Hold cfg_valid until the handshake completes (bounded).
   task automatic offer(logic [7:0] d, logic [7:0] n, logic [7:0] m);
      bit hs;
      int k;
      cfg_div = d; cfg_num = n; cfg_den = m; cfg_valid = 1'b1;
      for (k = 0; k < 200; k++) begin
         hs = !pnd_v;
         cycle();
         if (hs) break;
      end
      cfg_valid = 1'b0;
      checks++;
      assert (k < 200) else begin
         errors++;
         $error("FAIL offer_timeout: observed %0d cycles expected below 200", k);
      end
   endtask

   // Advance until the current cycle is expected to be a frame start (bounded).
   task automatic wait_fs();
      int k;
      for (k = 0; k < 200; k++) begin
         if (m_run && fq[0][0]) break;
         cycle();
      end
      checks++;
      assert (k < 200) else begin
         errors++;
         $error("FAIL frame_start_timeout: observed %0d cycles expected below 200", k);
      end
   endtask

   initial begin
      rst = 1'b0; en = 1'b0; cfg_valid = 1'b0;
      cfg_div = '0; cfg_num = '0; cfg_den = '0;
      model_reset();
      #2;
      check_all();
      #10 rst = 1'b1;

      // D=2, num=0, den=1: clk_out 1,0 from T+2.
      en = 1'b1;
      offer(8'd2, 8'd0, 8'd1);
      run(10);

      // D=2, num=1, den=3: periods 2,2,3.
      offer(8'd2, 8'd1, 8'd3);
      run(24);

      // Illegal offers: D<2, den==0, num>den.
      offer(8'd1, 8'd0, 8'd1);
      run(2);
      offer(8'd4, 8'd0, 8'd0);
      run(2);
      offer(8'd2, 8'd4, 8'd3);
      run(4);

      // Reconfigure mid-frame; takes effect at the next boundary.
      offer(8'd4, 8'd0, 8'd4);
      wait_fs();
      run(1);
      wait_fs();
      run(6);
      offer(8'd3, 8'd1, 8'd2);
      run(30);

      // en drop mid-frame: frame completes, then idle, then restart.
      offer(8'd2, 8'd1, 8'd3);
      wait_fs();
      run(1);
      wait_fs();
      run(2);
      en = 1'b0;
      run(10);
      en = 1'b1;
      run(12);

      // Asynchronous reset mid-period while clk_out is high.
      wait_fs();
      #3 rst = 1'b0;
      #1;
      model_reset();
      check_all();
      #2 rst = 1'b1;
      run(8);
      offer(8'd3, 8'd2, 8'd3);
      run(20);

      // Random traffic with small configs, some illegal.
      for (int i = 0; i < 1500; i++) begin
         en        = ($urandom_range(0, 24) != 0);
         cfg_valid = ($urandom_range(0, 9) == 0);
         cfg_div   = 8'($urandom_range(0, 6));
         cfg_num   = 8'($urandom_range(0, 5));
         cfg_den   = 8'($urandom_range(0, 5));
         cycle();
      end
      cfg_valid = 1'b0;
      run(5);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
